// File: rtl/aes_block_serializer_if.sv
// Handshake bundle between the AES core (block side) and the byte-link transmitter.
// The serializer takes the slave view; whatever drives blocks and sinks bytes takes the master view.
interface aes_block_serializer_if #(
    parameter int BLOCK_W = 128,
    parameter int BYTE_W  = 8
);
    logic [BLOCK_W-1:0] data_in;
    logic               in_valid;
    logic               in_ready;
    logic [BYTE_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;
    logic [3:0]         byte_cnt;

    modport slave (
        input  data_in, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy, byte_cnt
    );

    modport master (
        output data_in, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy, byte_cnt
    );
endinterface

// File: rtl/aes_block_serializer.sv
// Turns 128-bit AES blocks into a gap-free byte stream. A one-block pending
// buffer lets the next block arrive while the current one is still draining.
module aes_block_serializer #(
    parameter int BLOCK_W   = 128,
    parameter int BYTE_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_block_serializer_if.slave bus
);
    localparam int         NBYTES   = BLOCK_W / BYTE_W;
    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;

    state_e             state_r, state_s;
    logic [BLOCK_W-1:0] sr_r, sr_s;
    logic [BLOCK_W-1:0] pr_r, pr_s;
    logic               pend_r, pend_s;
    logic [3:0]         cnt_r, cnt_s;

    logic               accept_s;
    logic               byte_hs_s;
    logic               last_hs_s;
    logic [BLOCK_W-1:0] sr_shift_s;

    // Handshake qualifiers; in_ready depends only on the pending flag.
    assign accept_s   = bus.in_valid && !pend_r;
    assign byte_hs_s  = (state_r == ST_SHIFT) && bus.out_ready;
    assign last_hs_s  = byte_hs_s && (cnt_r == LAST_IDX);
    assign sr_shift_s = MSB_FIRST ? (sr_r << BYTE_W) : (sr_r >> BYTE_W);

    // Next-state logic for the IDLE/SHIFT controller and its datapath registers.
    always_comb begin
        state_s = state_r;
        sr_s    = sr_r;
        pr_s    = pr_r;
        pend_s  = pend_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    sr_s    = bus.data_in;
                    cnt_s   = 4'd0;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_hs_s) begin
                    // Refill from the pending buffer first, then from a same-cycle offer, so no bubble appears.
                    if (pend_r) begin
                        sr_s   = pr_r;
                        pend_s = 1'b0;
                        cnt_s  = 4'd0;
                    end else if (accept_s) begin
                        sr_s  = bus.data_in;
                        cnt_s = 4'd0;
                    end else begin
                        sr_s    = sr_shift_s;
                        cnt_s   = 4'd0;
                        state_s = ST_IDLE;
                    end
                end else begin
                    if (byte_hs_s) begin
                        sr_s  = sr_shift_s;
                        cnt_s = cnt_r + 4'd1;
                    end else begin
                        sr_s = sr_r;
                    end
                    if (accept_s) begin
                        pr_s   = bus.data_in;
                        pend_s = 1'b1;
                    end else begin
                        pend_s = pend_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                pend_s  = 1'b0;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State and storage registers; reset discards both blocks and the byte count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            sr_r    <= '0;
            pr_r    <= '0;
            pend_r  <= 1'b0;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            sr_r    <= sr_s;
            pr_r    <= pr_s;
            pend_r  <= pend_s;
            cnt_r   <= cnt_s;
        end
    end

    assign bus.in_ready  = !pend_r;
    assign bus.out_valid = (state_r == ST_SHIFT);
    assign bus.out_last  = (state_r == ST_SHIFT) && (cnt_r == LAST_IDX);
    assign bus.out_data  = MSB_FIRST ? sr_r[BLOCK_W-1 -: BYTE_W] : sr_r[BYTE_W-1:0];
    assign bus.busy      = (state_r == ST_SHIFT) || pend_r;
    assign bus.byte_cnt  = cnt_r;
endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed bench for aes_block_serializer: MSB-first and LSB-first instances,
// back-to-back blocks, stalls, mid-stream reset and coincident refill.
module tb_aes_block_serializer;
    localparam int BW = 128;
    localparam int YW = 8;

    localparam logic [127:0] B1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] B2 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] B3 = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    aes_block_serializer_if #(.BLOCK_W(BW), .BYTE_W(YW)) bm ();
    aes_block_serializer_if #(.BLOCK_W(BW), .BYTE_W(YW)) bl ();

    aes_block_serializer #(.BLOCK_W(BW), .BYTE_W(YW), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .bus(bm.slave)
    );
    aes_block_serializer #(.BLOCK_W(BW), .BYTE_W(YW), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(bl.slave)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte k of a block in emission order.
    function automatic logic [7:0] exp_byte(input logic [127:0] blk, input int k, input bit msb);
        int idx;
        idx = msb ? (15 - k) : k;
        return blk[idx*8 +: 8];
    endfunction

    task automatic chk_m_byte(input logic [127:0] blk, input int k);
        chk("m_valid", 128'(bm.out_valid), 128'(1'b1));
        chk("m_data",  128'(bm.out_data),  128'(exp_byte(blk, k, 1'b1)));
        chk("m_last",  128'(bm.out_last),  128'(k == 15));
        chk("m_cnt",   128'(bm.byte_cnt),  128'(k));
    endtask

    task automatic chk_m_idle(input string tag);
        chk({tag, "_valid"}, 128'(bm.out_valid), 128'(1'b0));
        chk({tag, "_busy"},  128'(bm.busy),      128'(1'b0));
        chk({tag, "_ready"}, 128'(bm.in_ready),  128'(1'b1));
    endtask

    task automatic offer_m(input logic [127:0] blk);
        bm.data_in  = blk;
        bm.in_valid = 1'b1;
    endtask

    initial begin
        int idx;
        int c;
        bit rdy;
        bm.data_in = '0; bm.in_valid = 1'b0; bm.out_ready = 1'b1;
        bl.data_in = '0; bl.in_valid = 1'b0; bl.out_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_valid", 128'(bm.out_valid), 128'(1'b0));
        chk("rst_last",  128'(bm.out_last),  128'(1'b0));
        chk("rst_data",  128'(bm.out_data),  128'(8'h00));
        chk("rst_busy",  128'(bm.busy),      128'(1'b0));
        chk("rst_ready", 128'(bm.in_ready),  128'(1'b1));
        chk("rst_cnt",   128'(bm.byte_cnt),  128'(4'd0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single block, MSB first
        offer_m(B1);
        @(negedge clk);
        bm.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk_m_byte(B1, k);
            @(negedge clk);
        end
        chk_m_idle("single_end");

        // Two blocks back to back: 32 contiguous bytes
        offer_m(B1);
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            chk_m_byte((k < 16) ? B1 : B2, k % 16);
            if (k == 0) begin
                chk("b2b_ready0", 128'(bm.in_ready), 128'(1'b1));
                offer_m(B2);
            end else begin
                bm.in_valid = 1'b0;
                chk("b2b_ready", 128'(bm.in_ready), 128'((k >= 16) ? 1'b1 : 1'b0));
                chk("b2b_busy",  128'(bm.busy),     128'(1'b1));
            end
            @(negedge clk);
        end
        chk_m_idle("b2b_end");

        // Stall pattern 1,0,0,1 on out_ready
        offer_m(B2);
        @(negedge clk);
        bm.in_valid = 1'b0;
        idx = 0;
        c = 0;
        while (idx < 16 && c < 200) begin
            chk_m_byte(B2, idx);
            rdy = (c % 4 == 0) || (c % 4 == 3);
            bm.out_ready = rdy;
            @(negedge clk);
            if (rdy) idx++;
            c++;
        end
        if (idx < 16) chk("stall_timeout", 128'(idx), 128'(16));
        bm.out_ready = 1'b1;
        chk_m_idle("stall_end");

        // LSB-first instance
        bl.data_in  = B1;
        bl.in_valid = 1'b1;
        @(negedge clk);
        bl.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("l_valid", 128'(bl.out_valid), 128'(1'b1));
            chk("l_data",  128'(bl.out_data),  128'(exp_byte(B1, k, 1'b0)));
            chk("l_last",  128'(bl.out_last),  128'(k == 15));
            @(negedge clk);
        end
        chk("l_end_valid", 128'(bl.out_valid), 128'(1'b0));

        // Reset at byte 7 with a block pending
        offer_m(B1);
        @(negedge clk);
        offer_m(B2);
        @(negedge clk);
        bm.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_cnt",   128'(bm.byte_cnt), 128'(4'd7));
        chk("pre_rst_ready", 128'(bm.in_ready), 128'(1'b0));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(bm.out_valid), 128'(1'b0));
        chk("mid_rst_ready", 128'(bm.in_ready),  128'(1'b1));
        chk("mid_rst_cnt",   128'(bm.byte_cnt),  128'(4'd0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_m_idle("post_rst");
        end
        offer_m(B3);
        @(negedge clk);
        bm.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk_m_byte(B3, k);
            @(negedge clk);
        end
        chk_m_idle("a5_end");

        // Final-byte handshake coincident with a new offer, pending empty
        offer_m(B1);
        @(negedge clk);
        bm.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk_m_byte(B1, k);
            if (k == 15) offer_m(B2);
            @(negedge clk);
        end
        bm.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk_m_byte(B2, k);
            chk("refill_ready", 128'(bm.in_ready), 128'(1'b1));
            @(negedge clk);
        end
        chk_m_idle("refill_end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/aes_block_serializer.md
Name: aes_block_serializer

Overview:
Consumer end of the 128-bit AES data_out bus. Accepts whole 128-bit blocks (ciphertext or state) over a valid/ready handshake. Streams each block out as 16 bytes over a byte-wide valid/ready/last interface toward a UART/byte-link transmitter. A one-block pending buffer lets the core hand over the next block while the current one drains, so the byte stream has no gaps.

Parameters:
BLOCK_W, 128, input block width in bits; must be a multiple of BYTE_W.
BYTE_W, 8, output symbol width in bits.
MSB_FIRST, 1, 1 = emit bits [BLOCK_W-1 -: BYTE_W] first; 0 = emit bits [BYTE_W-1:0] first.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  BLOCK_W  block from AES core
in_valid  input  1  data_in valid
in_ready  output  1  block accepted when in_valid && in_ready
out_data  output  BYTE_W  current byte
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts byte when out_valid && out_ready
out_last  output  1  high with final byte of a block
busy  output  1  shift register or pending buffer occupied
byte_cnt  output  4  index of the byte currently presented (0..15)

Behaviour:
- Reset (async assert, sync release): state=IDLE, shift reg=0, pending empty, byte_cnt=0, out_valid=0, out_last=0, out_data=0, busy=0, in_ready=1.
- Reset mid-operation discards the current block, the pending block, and all count state. No partial byte is emitted after release.
- Storage: shift register SR (BLOCK_W), pending register PR (BLOCK_W) with flag pend_v.
- in_ready = !pend_v. It is combinational from registers only, never from in_valid or out_ready.
- FSM states IDLE and SHIFT. out_valid = (state==SHIFT).
- Accept in IDLE: the block loads directly into SR, byte_cnt=0, next state SHIFT. out_valid rises the cycle after acceptance (latency 1).
- Accept in SHIFT when no final-byte handshake is occurring: the block goes to PR and pend_v is set.
- Byte handshake with byte_cnt<15: SR shifts by BYTE_W toward the output end and byte_cnt increments.
- Final-byte handshake (byte_cnt==15), one of three cases:
  - pend_v=1: SR<=PR, pend_v clears, byte_cnt=0, stay SHIFT.
  - pend_v=0 and an accept occurs in the same cycle: SR<=data_in, byte_cnt=0, stay SHIFT. No bubble.
  - Otherwise: go to IDLE.
- out_data = SR[BLOCK_W-1 -: BYTE_W] when MSB_FIRST=1, else SR[BYTE_W-1:0].
- out_last = SHIFT && byte_cnt==15.
- While out_valid && !out_ready, out_data, out_last and byte_cnt hold stable.
- out_valid never drops without a handshake, except on reset.
- busy = (state==SHIFT) || pend_v.
- in_valid while in_ready=0: the bench must hold data_in stable. The block ignores it until ready.
- Throughput: with out_ready held at 1 and blocks always offered, 1 byte/cycle sustained. Block acceptance averages 1 per 16 cycles.

Test Plan:
- Single block 0x00112233445566778899AABBCCDDEEFF, out_ready=1, MSB_FIRST=1 -> bytes 00,11,...,FF on the 16 cycles after acceptance; out_last only with FF; out_valid=0 and busy=0 afterwards.
- Two blocks offered back-to-back, out_ready=1 -> 32 contiguous bytes with no idle cycle; in_ready=0 while the second block sits pending; out_last on bytes 16 and 32.
- out_ready pattern 1,0,0,1 repeating on block 0x0F0E...00 -> every byte held stable through the stalls; order 0F,0E,...,00; byte_cnt frozen during stalls.
- MSB_FIRST=0 with block 0x00112233445566778899AABBCCDDEEFF -> first byte FF, last byte 00 with out_last.
- rst_n pulsed low at byte_cnt=7 with a block pending -> out_valid=0 and in_ready=1 immediately; after release a new block 0xA5A5... streams from byte 0; no stale bytes appear.
- Final-byte handshake coincident with in_valid (pending empty) -> the new block's first byte appears the next cycle; no bubble; no pend_v assertion.
